// File: rtl/mul_acc_unit.sv
// rtl/mul_acc_unit.sv - multiply / multiply-accumulate unit with a shared half-width accumulate adder
//
// One operation in flight. MUL holds for MUL_LAT cycles. MADD/MSUB then add
// or subtract the product into {hi,lo} one half per cycle. A single
// WIDTH-bit adder does both halves, with the carry or borrow saved in between.

module mul_acc_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           op,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic [2*WIDTH-1:0]   hilo,
  input  logic                 cancel,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy
);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MADD  = 2'b01;
  localparam logic [1:0] OP_MSUB  = 2'b10;
  localparam logic [1:0] OP_MULLO = 2'b11;

  // MUL_LAT is at most 8, so 4 bits cover every count
  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL    = 3'd1,
    ACC_LO = 3'd2,
    ACC_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;

  // operation captured at transfer; later input changes cannot disturb it
  logic [1:0]           op_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   hilo_q;

  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   res_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 carry_q;

  logic                 accept;
  logic                 mul_last;
  logic                 is_acc_op;
  logic                 is_sub;

  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   product;

  logic                 hi_sel;
  logic [WIDTH-1:0]     add_x;
  logic [WIDTH-1:0]     add_y;
  logic                 add_cin;
  logic [WIDTH:0]       add_sum;
  logic                 add_cout;

  assign accept    = req_valid && req_ready;
  assign mul_last  = (cnt_q == CNT_LAST);
  assign is_acc_op = (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign is_sub    = (op_q == OP_MSUB);

  // Extending by one bit and then taking the product modulo 2^(2W) gives the
  // same result as extending each operand straight to 2W bits. The low 2W
  // bits of the product are therefore all that is needed.
  assign ext_a   = {{WIDTH{sign_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{sign_q & b_q[WIDTH-1]}}, b_q};
  assign product = ext_a * ext_b;

  // Shared half-width adder: low halves in ACC_LO, high halves plus saved carry/borrow in ACC_HI
  always_comb begin
    hi_sel  = (state == ACC_HI);
    add_x   = hi_sel ? hilo_q[2*WIDTH-1:WIDTH] : hilo_q[WIDTH-1:0];
    add_y   = hi_sel ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
    add_cin = hi_sel ? carry_q : 1'b0;
    // subtract as x + ~y + !borrow_in; borrow_out is the inverted carry
    if (is_sub) begin
      add_y   = ~add_y;
      add_cin = ~add_cin;
    end
    add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_cout = is_sub ? ~add_sum[WIDTH] : add_sum[WIDTH];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; cancel overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = MUL;
      end
      MUL: begin
        if (mul_last) state_nxt = is_acc_op ? ACC_LO : DONE;
      end
      ACC_LO: state_nxt = ACC_HI;
      ACC_HI: state_nxt = DONE;
      DONE: begin
        if (res_ready) state_nxt = accept ? MUL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  // Outputs; req_ready is gated by rst because reset holds the FSM in IDLE
  always_comb begin
    req_ready = !rst && !cancel && ((state == IDLE) || ((state == DONE) && res_ready));
    res_valid = (state == DONE);
    busy      = (state != IDLE);
    res       = res_valid ? res_q : '0;
  end

  // Operand capture, multiply latency count, and accumulate datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_MULT;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      sign_q  <= is_signed;
      a_q     <= src_a;
      b_q     <= src_b;
      hilo_q  <= hilo;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else if (!cancel) begin
      case (state)
        MUL: begin
          cnt_q  <= cnt_q + CNT_W'(1);
          prod_q <= product;
          if (mul_last && !is_acc_op) begin
            res_q <= (op_q == OP_MULLO) ? {{WIDTH{1'b0}}, product[WIDTH-1:0]} : product;
          end
        end
        ACC_LO: begin
          res_q[WIDTH-1:0] <= add_sum[WIDTH-1:0];
          carry_q          <= add_cout;
        end
        ACC_HI: begin
          res_q[2*WIDTH-1:WIDTH] <= add_sum[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_acc_unit.sv
// tb/tb_mul_acc_unit.sv - self-checking bench for mul_acc_unit

module tb_mul_acc_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    op = 2'b00;
  logic          is_signed = 1'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [2*W-1:0] hilo = '0;
  logic          cancel = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [2*W-1:0] res;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_acc_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .hilo      (hilo),
    .cancel    (cancel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Arithmetic meaning of each operation, on 64-bit values
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic s,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] h);
    logic [63:0] ea, eb, p;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    case (o)
      2'b00:   return p;
      2'b01:   return h + p;
      2'b10:   return h - p;
      default: return {32'd0, p[31:0]};
    endcase
  endfunction

  // Model: pending result, edges left until visible, value
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res  = '0;

  initial forever begin
    logic rdy_e;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pend = 1'b0;
      m_left = 0;
    end else begin
      rdy_e = !cancel && (!m_pend || (m_left == 0 && res_ready));
      if (cancel) begin
        m_pend = 1'b0;
      end else begin
        if (m_pend && m_left == 0 && res_ready) m_pend = 1'b0;
        else if (m_pend && m_left != 0) m_left = m_left - 1;
        if (req_valid && rdy_e) begin
          m_pend = 1'b1;
          m_left = (op == 2'b01 || op == 2'b10) ? LAT + 2 : LAT;
          m_res  = model_res(op, is_signed, src_a, src_b, hilo);
        end
      end
    end
  end

  // Compare every cycle against the model
  initial forever begin
    logic exp_v;
    @(negedge clk);
    if (!rst) begin
      exp_v = m_pend && (m_left == 0);
      chk("res_valid", 64'(res_valid), 64'(exp_v));
      chk("res", res, exp_v ? m_res : 64'd0);
      chk("busy", 64'(busy), 64'(m_pend));
      chk("req_ready", 64'(req_ready), 64'(!cancel && (!m_pend || (exp_v && res_ready))));
    end
  end

  // Present a request until accepted; scramble inputs afterwards
  task automatic send(input logic [1:0] o, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] h, output int n);
    logic rdy;
    req_valid = 1'b1; op = o; is_signed = s; src_a = a; src_b = b; hilo = h;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 30) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      n++;
    end
    #2;
    if (!rdy) timeout("send_accept");
    req_valid = 1'b0;
    op        = 2'($urandom);
    is_signed = 1'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
    hilo      = {$urandom, $urandom};
  endtask

  // Count edges from transfer to res_valid; take the result
  task automatic wait_valid(output int lat, output logic [63:0] r);
    logic found;
    found = 1'b0;
    lat = 0;
    r = '0;
    while (!found && lat < 20) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
        r = res;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!found) timeout("wait_valid");
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input string name, input logic [1:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] h,
                         input logic [63:0] exp_r, input int exp_lat);
    int n, lat;
    logic [63:0] r;
    res_ready = 1'b1;
    send(o, s, a, b, h, n);
    wait_valid(lat, r);
    chk({name, "_res"}, r, exp_r);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int n, lat;
    logic [63:0] r;

    // reset state
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // pin the model itself
    chk("pin_mult_signed", model_res(2'b00, 1'b1, 32'hFFFFFFFF, 32'd2, 64'd0), 64'hFFFFFFFF_FFFFFFFE);
    chk("pin_madd_carry", model_res(2'b01, 1'b0, 32'd1, 32'd1, 64'h00000000_FFFFFFFF), 64'h00000001_00000000);
    chk("pin_msub_borrow", model_res(2'b10, 1'b0, 32'd1, 32'd1, 64'd0), 64'hFFFFFFFF_FFFFFFFF);
    chk("pin_mullo", model_res(2'b11, 1'b0, 32'h00010000, 32'h00010000, 64'd0), 64'd0);

    // first transfer on the first edge after reset release
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(2'b00, 1'b1, 32'hFFFFFFFF, 32'd2, 64'd0, n);
    chk("first_xfer_edge", 64'(n), 64'd1);
    wait_valid(lat, r);
    chk("mult_s_res", r, 64'hFFFFFFFF_FFFFFFFE);
    chk("mult_s_lat", 64'(lat), 64'd2);

    // directed vectors
    run_vec("mult_u",    2'b00, 1'b0, 32'hFFFFFFFF, 32'd2, 64'd0, 64'h00000001_FFFFFFFE, 2);
    run_vec("madd_c",    2'b01, 1'b0, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, 64'h00000001_00000000, 4);
    run_vec("msub_b",    2'b10, 1'b0, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 4);
    run_vec("mullo_0",   2'b11, 1'b0, 32'h00010000, 32'h00010000, 64'd0, 64'd0, 2);
    run_vec("madd_s",    2'b01, 1'b1, 32'hFFFFFFFD, 32'd5, 64'h10, 64'd1, 4);
    run_vec("msub_s",    2'b10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001_00000000, 64'h00000000_FFFFFFFF, 4);
    run_vec("mult_max",  2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 2);
    run_vec("mullo_s",   2'b11, 1'b1, 32'hFFFFFFFF, 32'd3, 64'd0, 64'h00000000_FFFFFFFD, 2);
    run_vec("madd_wrap", 2'b01, 1'b0, 32'd2, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 4);

    // held result under backpressure, then back-to-back accept
    res_ready = 1'b0;
    send(2'b00, 1'b0, 32'd3, 32'd7, 64'd0, n);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) timeout("hold_valid");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_res", res, 64'd21);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    send(2'b00, 1'b0, 32'd5, 32'd6, 64'd0, n);
    chk("b2b_accept_edge", 64'(n), 64'd1);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_valid(lat, r);
    chk("b2b_res", r, 64'd30);
    chk("b2b_lat", 64'(lat), 64'd2);

    // cancel while idle has no effect
    cancel = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #2;
    cancel = 1'b0;
    req_valid = 1'b0;
    chk("idle_cancel_busy", 64'(busy), 64'd0);
    run_vec("after_idle_cancel", 2'b00, 1'b0, 32'd4, 32'd4, 64'd0, 64'd16, 2);

    // cancel in ACC_LO
    send(2'b01, 1'b0, 32'd2, 32'd3, 64'd5, n);
    @(posedge clk);
    @(posedge clk);
    #2;
    cancel = 1'b1;
    @(posedge clk);
    #2;
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cancel_no_valid", 64'(res_valid), 64'd0);
    end
    @(posedge clk);
    #2;
    run_vec("after_cancel", 2'b00, 1'b0, 32'd7, 32'd9, 64'd0, 64'd63, 2);

    // asynchronous reset pulse in ACC_HI
    send(2'b01, 1'b0, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, n);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("acc_hi_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res", res, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_valid", 64'(res_valid), 64'd0);
    end
    @(posedge clk);
    #2;
    run_vec("after_arst", 2'b10, 1'b0, 32'd2, 32'd2, 64'd10, 64'd6, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_acc_unit.md
MUL_ACC_UNIT -- requirements
Module: mul_acc_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the result is 2*WIDTH bits.
REQ-002 Parameter MUL_LAT, default 2, number of multiply pipeline cycles; legal range 1..8.
REQ-003 Reset is asynchronous and active-high; one clock; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  an operation is presented.
REQ-007 req_ready  output  1  the unit accepts this cycle; transfer occurs when req_valid && req_ready.
REQ-008 op  input  2  operation: 00 MULT (full product), 01 MADD, 10 MSUB, 11 MULLO (low word only).
REQ-009 is_signed  input  1  operands are treated as two's complement.
REQ-010 src_a, src_b  input  WIDTH  multiplicand and multiplier.
REQ-011 hilo  input  2*WIDTH  accumulator source {hi,lo}; sampled only at transfer.
REQ-012 cancel  input  1  flushes any in-flight or held operation.
REQ-013 res_valid  output  1  res is valid.
REQ-014 res_ready  input  1  the consumer takes res; result transfer occurs when res_valid && res_ready.
REQ-015 res  output  2*WIDTH  result.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, MUL, ACC_LO, ACC_HI and DONE.
REQ-018 On transfer the unit SHALL register op, is_signed, src_a, src_b and hilo, clear the cycle counter, and enter MUL.
REQ-019 Later input changes SHALL NOT affect an accepted operation.
REQ-020 The multiply SHALL sign- or zero-extend each operand by 1 bit according to is_signed and form the product modulo 2^(2*WIDTH).
REQ-021 MUL SHALL last exactly MUL_LAT cycles, then go to DONE for MULT/MULLO and to ACC_LO for MADD/MSUB.
REQ-022 ACC_LO SHALL compute lo ± product[WIDTH-1:0] in one WIDTH-bit adder, registering the low sum and the carry (MADD) or borrow (MSUB).
REQ-023 ACC_HI SHALL compute hi ± product[2W-1:W] ± the saved carry/borrow, then go to DONE.
REQ-024 There SHALL be a single WIDTH-bit adder, shared by the two accumulate cycles.
REQ-025 The MADD/MSUB result SHALL equal hilo ± product modulo 2^(2*WIDTH); overflow SHALL wrap silently with no flag.
REQ-026 The MULLO result SHALL be {WIDTH zeros, product[WIDTH-1:0]}.
REQ-027 Latency from the transfer edge to res_valid SHALL be MUL_LAT cycles for MULT/MULLO and MUL_LAT+2 cycles for MADD/MSUB.
REQ-028 In DONE, res_valid SHALL be 1 and res SHALL be held stable until res_ready.
REQ-029 On result transfer the unit SHALL return to IDLE, unless a new request transfers in the same cycle, in which case it goes directly to MUL.
REQ-030 req_ready SHALL equal !cancel && (state==IDLE || (state==DONE && res_ready)); there is at most one operation in flight.
REQ-031 cancel SHALL take priority over everything except rst: the next edge forces IDLE, res_valid=0, and no request is accepted that cycle.
REQ-032 cancel while in IDLE SHALL have no effect.
REQ-033 res SHALL be 0 whenever res_valid=0.

Reset
REQ-034 rst SHALL immediately force IDLE, res_valid=0, res=0, busy=0, req_ready=0, the counter to 0 and the saved carry to 0, including mid-operation.
REQ-035 The first transfer after reset SHALL be possible on the first edge after rst deasserts.

Verification (WIDTH=32, MUL_LAT=2)
REQ-036 MULT signed, src_a=0xFFFFFFFF, src_b=2 -> res=0xFFFFFFFF_FFFFFFFE with res_valid 2 cycles after transfer; unsigned, same operands -> 0x00000001_FFFFFFFE.
REQ-037 MADD unsigned, hilo=0x00000000_FFFFFFFF, src_a=src_b=1 -> res=0x00000001_00000000 at 4 cycles (carry crosses halves).
REQ-038 MSUB unsigned, hilo=0, src_a=src_b=1 -> res=0xFFFFFFFF_FFFFFFFF (borrow wrap); MULLO, 0x00010000*0x00010000 -> res=0.
REQ-039 MULT accepted, res_ready=0 for 3 cycles -> res stable, req_ready=0; then res_ready=1 with req_valid=1 -> new op accepted that edge, busy stays 1, next res after 2 cycles.
REQ-040 MADD cancelled in ACC_LO -> IDLE next edge, res_valid never asserted, the following MULT gives the correct result.
REQ-041 rst pulsed asynchronously (between edges) in ACC_HI -> outputs zero at once, with no res_valid after release.
